fifo8_word_packer: RTL and testbench

- Drain-side stage placed directly downstream of the 8-deep byte FIFO (FIFO_8).
- Mirrors the FIFO occupancy from the write strobe and issues `ren` only when data is present, so the FIFO never flags an underflow.
- Packs consecutive bytes into little-endian 32-bit words and hands each word to the consumer over a valid/ready handshake.

---
 rtl/fifo8_pkg.sv | 14 +
 rtl/fifo8_occ_mirror.sv | 38 +++
 rtl/fifo8_word_packer.sv | 113 +++++++++++
 tb/tb_fifo8_word_packer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo8_pkg.sv
// fifo8_pkg: shared constants and types for
// the FIFO_8 drain-side word packer.
package fifo8_pkg;

  localparam int FIFO_DW    = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int OCC_W      = 4;

  typedef enum logic {
    FILL,
    OUT
  } state_e;

endpackage

// File: rtl/fifo8_occ_mirror.sv
// fifo8_occ_mirror: tracks FIFO_8 occupancy
// from its read/write strobes, saturating.
module fifo8_occ_mirror
  import fifo8_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic             ren,
  output logic [OCC_W-1:0] occ,
  output logic [OCC_W-1:0] occ_nxt
);

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  // read wins over write; full writes are dropped
  always_comb begin
    occ_d = occ_q;
    if (ren) begin
      if (occ_q != '0) occ_d = occ_q - OCC_W'(1);
    end else if (wen && (occ_q < OCC_W'(DEPTH))) begin
      occ_d = occ_q + OCC_W'(1);
    end
  end

  // occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign occ     = occ_q;
  assign occ_nxt = occ_d;

endmodule

// File: rtl/fifo8_word_packer.sv
// fifo8_word_packer: drains FIFO_8 without
// underflow, packs bytes into LE words.
module fifo8_word_packer
  import fifo8_pkg::*;
#(
  parameter int DW    = FIFO_DW,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int BPW   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_wen,
  output logic              fifo_ren,
  output logic              fifo_wr_stall,
  input  logic [DW-1:0]     fifo_dout,
  input  logic              fifo_error,
  output logic [DW*BPW-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [OCC_W-1:0]  occ,
  output logic              err_sticky
);

  localparam int WW = DW * BPW;
  localparam int CW = $clog2(BPW + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   issue_q, issue_d;
  logic [CW-1:0]   cap_q, cap_d;
  logic            ren_q, ren_d;
  logic            pend_q, pend_d;
  logic [WW-1:0]   data_q, data_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [OCC_W-1:0] occ_nxt;

  fifo8_occ_mirror #(
    .DEPTH(DEPTH)
  ) u_mirror (
    .clk    (clk),
    .rst_n  (rst_n),
    .wen    (fifo_wen),
    .ren    (ren_q),
    .occ    (occ),
    .occ_nxt(occ_nxt)
  );

  // next state, capture and read-issue decision
  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    cap_d   = cap_q;
    data_d  = data_q;
    valid_d = valid_q;
    pend_d  = ren_q;
    err_d   = err_q | fifo_error;
    if (ren_q) issue_d = issue_q + CW'(1);
    unique case (state_q)
      FILL: begin
        if (pend_q) begin
          data_d[int'(cap_q)*DW +: DW] = fifo_dout;
          cap_d = cap_q + CW'(1);
          if (cap_d == CW'(BPW)) begin
            state_d = OUT;
            valid_d = 1'b1;
            cap_d   = '0;
            issue_d = '0;
          end
        end
      end
      OUT: begin
        if (valid_q && word_ready) begin
          state_d = FILL;
          valid_d = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
    // reads only start a cycle after OUT is left
    ren_d = (state_q == FILL) && (state_d == FILL)
         && (occ_nxt != '0) && (issue_d < CW'(BPW));
  end

  // packer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      issue_q <= '0;
      cap_q   <= '0;
      ren_q   <= 1'b0;
      pend_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      cap_q   <= cap_d;
      ren_q   <= ren_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign fifo_ren      = ren_q;
  assign fifo_wr_stall = ren_q;
  assign word_data     = data_q;
  assign word_valid    = valid_q;
  assign err_sticky    = err_q;

endmodule

// File: tb/tb_fifo8_word_packer.sv
// tb_fifo8_word_packer: FIFO_8 model plus
// packer checks, directed and random.
module tb_fifo8_word_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fifo_wen = 1'b0;
  logic        fifo_ren;
  logic        fifo_wr_stall;
  logic [7:0]  fifo_dout = '0;
  logic        fifo_error = 1'b0;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [3:0]  occ;
  logic        err_sticky;

  logic [7:0]  wdata = '0;
  logic [7:0]  pop_b;
  logic [7:0]  fq[$];
  logic [7:0]  popq[$];
  bit          err_model = 1'b0;
  bit          uf_seen = 1'b0;

  int nvec = 0;
  int nerr = 0;

  fifo8_word_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_wen     (fifo_wen),
    .fifo_ren     (fifo_ren),
    .fifo_wr_stall(fifo_wr_stall),
    .fifo_dout    (fifo_dout),
    .fifo_error   (fifo_error),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .occ          (occ),
    .err_sticky   (err_sticky)
  );

  always #5 clk = ~clk;

  // behavioural FIFO_8: read beats write, errors pulse
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      popq.delete();
      err_model = 1'b0;
      fifo_dout <= '0;
      fifo_error <= 1'b0;
    end else begin
      if (fifo_error) err_model = 1'b1;
      fifo_error <= 1'b0;
      if (fifo_ren) begin
        if (fq.size() != 0) begin
          pop_b = fq.pop_front();
          popq.push_back(pop_b);
          fifo_dout <= pop_b;
        end else begin
          fifo_error <= 1'b1;
          uf_seen = 1'b1;
        end
      end else if (fifo_wen) begin
        if (fq.size() >= 8) fifo_error <= 1'b1;
        else fq.push_back(wdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic push(input logic [7:0] b);
    logic st;
    int n;
    n = 0;
    do begin
      st = fifo_wr_stall;
      fifo_wen = 1'b1;
      wdata = b;
      @(negedge clk);
      n++;
    end while (st && n < 20);
    fifo_wen = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] b;
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (occ !== 4'd0)
      $display("FAIL rst_occ: got %0d want 0", occ);
    if (occ !== 4'd0) nerr++;
    nvec++;
    if (fifo_ren !== 1'b0 || word_valid !== 1'b0) begin
      $display("FAIL rst_ctl: got ren=%b vld=%b want 0 0",
               fifo_ren, word_valid);
      nerr++;
    end
    nvec++;
    if (word_data !== 32'h0 || err_sticky !== 1'b0) begin
      $display("FAIL rst_data: got %h/%b want 0/0",
               word_data, err_sticky);
      nerr++;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom) | 8'h01;
      push(b);
    end
    repeat (6) @(negedge clk);
    nvec++;
    if (word_valid !== 1'b0 || occ !== 4'd0) begin
      $display("FAIL part_word: got vld=%b occ=%0d want 0 0",
               word_valid, occ);
      nerr++;
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (word_data !== 32'h0 || fifo_ren !== 1'b0 ||
        occ !== 4'd0 || word_valid !== 1'b0) begin
      $display("FAIL midrst: got %h %b %0d %b want 0 0 0 0",
               word_data, fifo_ren, occ, word_valid);
      nerr++;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    word_ready = 1'b0;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    for (int i = 0; i < 30 && !word_valid; i++) @(negedge clk);
    nvec++;
    if (word_valid !== 1'b1) begin
      $display("FAIL fill_valid: got %b want 1", word_valid);
      nerr++;
    end
    nvec++;
    if (word_data !== 32'h04030201) begin
      $display("FAIL fill_data: got %h want 04030201", word_data);
      nerr++;
    end
    nvec++;
    if (err_sticky !== 1'b0 || err_model !== 1'b0) begin
      $display("FAIL fill_err: got %b/%b want 0/0",
               err_sticky, err_model);
      nerr++;
    end
    push(8'h11);
    push(8'h12);
    push(8'h13);
    push(8'h14);
    nvec++;
    if (occ !== 4'd4 || fifo_ren !== 1'b0) begin
      $display("FAIL fill_occ: got occ=%0d ren=%b want 4 0",
               occ, fifo_ren);
      nerr++;
    end
  endtask

  task automatic test_backpressure();
    logic er, ev;
    word_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      nvec++;
      if (word_data !== 32'h04030201 || fifo_ren !== 1'b0 ||
          word_valid !== 1'b1) begin
        $display("FAIL bp_hold%0d: got %h ren=%b vld=%b want 04030201 0 1",
                 i, word_data, fifo_ren, word_valid);
        nerr++;
      end
    end
    word_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      word_ready = 1'b0;
      er = (k >= 2 && k <= 5);
      ev = (k == 7);
      nvec++;
      if (fifo_ren !== er || word_valid !== ev) begin
        $display("FAIL bp_seq%0d: got ren=%b vld=%b want %b %b",
                 k, fifo_ren, word_valid, er, ev);
        nerr++;
      end
    end
    nvec++;
    if (word_data !== 32'h14131211) begin
      $display("FAIL bp_data: got %h want 14131211", word_data);
      nerr++;
    end
  endtask

  task automatic test_starvation();
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    push(8'h0A);
    push(8'h0B);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      nvec++;
      if (word_valid !== 1'b0 ||
          (fq.size() == 0 && fifo_ren !== 1'b0)) begin
        $display("FAIL starve%0d: got vld=%b ren=%b want 0 0",
                 i, word_valid, fifo_ren);
        nerr++;
      end
    end
    nvec++;
    if (occ !== 4'd0) begin
      $display("FAIL starve_occ: got %0d want 0", occ);
      nerr++;
    end
    push(8'h0C);
    push(8'h0D);
    for (int i = 0; i < 20 && !word_valid; i++) @(negedge clk);
    nvec++;
    if (word_valid !== 1'b1 || word_data !== 32'h0D0C0B0A) begin
      $display("FAIL starve_word: got %b %h want 1 0d0c0b0a",
               word_valid, word_data);
      nerr++;
    end
  endtask

  task automatic test_overflow();
    word_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      fifo_wen = 1'b1;
      wdata = 8'(8'h30 + i);
      @(negedge clk);
    end
    fifo_wen = 1'b0;
    nvec++;
    if (occ !== 4'd8) begin
      $display("FAIL ovf_occ: got %0d want 8", occ);
      nerr++;
    end
    nvec++;
    if (err_sticky !== 1'b1) begin
      $display("FAIL ovf_err: got %b want 1", err_sticky);
      nerr++;
    end
  endtask

  task automatic test_collision();
    int exp;
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    for (int i = 0; i < 10 && !fifo_ren; i++) @(negedge clk);
    exp = fq.size() - 1;
    fifo_wen = 1'b1;
    wdata = 8'hEE;
    nvec++;
    if (fifo_wr_stall !== 1'b1) begin
      $display("FAIL coll_stall: got %b want 1", fifo_wr_stall);
      nerr++;
    end
    @(negedge clk);
    fifo_wen = 1'b0;
    nvec++;
    if (occ !== 4'(exp)) begin
      $display("FAIL coll_occ: got %0d want %0d", occ, exp);
      nerr++;
    end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    logic        rdy;
    int          nwords;
    nwords = 0;
    word_ready = 1'b0;
    fifo_wen = 1'b0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      nvec++;
      if (occ !== 4'(fq.size())) begin
        $display("FAIL rnd_occ%0d: got %0d want %0d", i, occ, fq.size());
        nerr++;
      end
      nvec++;
      if (fifo_wr_stall !== fifo_ren) begin
        $display("FAIL rnd_stall%0d: got %b want %b",
                 i, fifo_wr_stall, fifo_ren);
        nerr++;
      end
      nvec++;
      if (err_sticky !== err_model) begin
        $display("FAIL rnd_err%0d: got %b want %b", i, err_sticky, err_model);
        nerr++;
      end
      rdy = ($urandom_range(0, 1) == 1);
      word_ready = rdy;
      if (word_valid && rdy) begin
        nvec++;
        if (popq.size() < 4) begin
          $display("FAIL rnd_bytes%0d: got %0d want 4", i, popq.size());
          nerr++;
        end else begin
          exp = {popq[3], popq[2], popq[1], popq[0]};
          repeat (4) pop_b = popq.pop_front();
          if (word_data !== exp) begin
            $display("FAIL rnd_word%0d: got %h want %h", i, word_data, exp);
            nerr++;
          end
        end
        nwords++;
      end
      fifo_wen = ($urandom_range(0, 2) != 0) &&
                 (!fifo_wr_stall || $urandom_range(0, 3) == 0);
      wdata = 8'($urandom);
    end
    fifo_wen = 1'b0;
    word_ready = 1'b0;
    nvec++;
    if (uf_seen !== 1'b0) begin
      $display("FAIL underflow: got %b want 0", uf_seen);
      nerr++;
    end
    nvec++;
    if (nwords < 10) begin
      $display("FAIL rnd_words: got %0d want >=10", nwords);
      nerr++;
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_backpressure();
    test_starvation();
    test_overflow();
    test_collision();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
